acc_requant: RTL
================

// Module: acc_requant
// PURPOSE
//   Reads the wide accumulator result of the FIR filter datapath and returns it to the
//   sample-width domain. Rounds the 2*cant_bits-1 bit Q(2*FRAC) sum to Q(FRAC), saturates it
//   to cant_bits signed, and hands it downstream over a valid/ready interface.
//   Counts saturation events for overflow monitoring. Sits between the accumulator and the
//   filter output port / DAC interface.
// PARAMETERS
//   cant_bits  25  sample width; the accumulator input is 2*cant_bits-1 bits, signed two's complement
//   FRAC       12  fractional bits of the sample format; legal range 1..cant_bits-1
//   CNT_W      16  width of the saturation event counter
// PORTS
//   clk        in   1              clock, rising edge
//   rst        in   1              reset, asynchronous, active-high
//   in_valid   in   1              acc_in holds a new accumulated sample
//   in_ready   out  1              block accepts acc_in this cycle
//   acc_in     in   2*cant_bits-1  signed accumulator value, Q(2*FRAC)
//   out_valid  out  1              out_data is valid
//   out_ready  in   1              downstream accepts out_data this cycle
//   out_data   out  cant_bits      signed rounded/saturated sample, Q(FRAC)
//   out_sat    out  1              the sample on out_data was saturated (qualified by out_valid)
//   clr_count  in   1              synchronous clear of sat_count
//   sat_count  out  CNT_W          number of saturated samples, sticks at all-ones
// BEHAVIOUR
//   Reset: rst is asynchronous, active-high, clock clk. On reset, stage-A and stage-B valid
//     bits are 0, out_valid=0, out_data=0, out_sat=0, sat_count=0, and in_ready=1 from the
//     first cycle after release.
//   Transfers: a transfer occurs on in_valid&&in_ready or out_valid&&out_ready at the rising clk.
//   Stage A (round): on accept, register r = (sign-extend acc_in to 2*cant_bits) + 2^(FRAC-1).
//     Round half up toward +inf; no overflow is possible at 2*cant_bits.
//   Stage B (shift and saturate): s = r >>> FRAC (arithmetic). s is clamped as follows:
//     s > 2^(cant_bits-1)-1 -> 2^(cant_bits-1)-1, and out_sat=1
//     s < -2^(cant_bits-1)  -> -2^(cant_bits-1),  and out_sat=1
//     otherwise s[cant_bits-1:0], and out_sat=0
//   Pipeline control:
//     advB = !out_valid || out_ready
//     advA = advB || !validA
//     in_ready = advA, combinational and independent of in_valid
//     Stage A loads on advA; stage B loads from A on advB.
//   Latency: accept at edge k -> out_valid=1 after edge k+1 when there is no back-pressure.
//     Sustained throughput is 1 sample/clk while out_ready=1.
//   Back-pressure: while out_valid && !out_ready, out_data/out_sat hold stable.
//     Stage A holds one more sample, after which in_ready=0. No sample is dropped or duplicated.
//   Bubbles: if in_valid=0 on a cycle where A advances, validA becomes 0.
//     out_valid falls only after the current sample is taken.
//   sat_count: increments by 1 when a saturated sample loads into stage B.
//     Holds at 2^CNT_W-1 and does not wrap.
//     clr_count has priority: on an edge with both clear and increment, the result is 0.
//   Reset mid-operation: in-flight samples in A and B are discarded and all outputs take
//     their reset values immediately. sat_count is cleared.
// TESTING  (cant_bits=25, FRAC=12)
//   1. acc_in=20480 (5*4096) with out_ready=1 -> two cycles later out_data=5, out_sat=0.
//   2. Rounding: acc_in=2048 -> 1; 2047 -> 0; -2048 -> 0; -2049 -> -1; all with out_sat=0.
//   3. Saturation: acc_in=2^48-1 -> 0xFFFFFF, out_sat=1; acc_in=-2^48 -> 0x1000000,
//      out_sat=1; sat_count=2; then clr_count=1 on the same edge as a third saturated
//      sample -> sat_count=0.
//   4. Stream of 8 samples 1..8 (*4096) with out_ready=1010 repeating -> out_data 1..8 in
//      order, no loss or duplicates, out_data stable while out_ready=0, in_ready=0 only when
//      A and B are both full.
//   5. Assert rst asynchronously between edges with A and B full -> out_valid=0, out_data=0,
//      sat_count=0 immediately; first sample after release appears with nominal latency.
//   6. Force sat_count to 0xFFFE, then send 3 saturated samples -> sat_count=0xFFFF, held.

Source files
------------

// File: rtl/acc_requant.sv
// Rounds a Q(2*FRAC) accumulator to Q(FRAC), saturates to cant_bits signed; 2-stage valid/ready pipe.
// Latency 2 clk, 1 sample/clk; stage A absorbs one sample under back-pressure before in_ready drops.
module acc_requant #(
    parameter int cant_bits = 25,
    parameter int FRAC      = 12,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2*cant_bits-2:0] acc_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [cant_bits-1:0]   out_data,
    output logic                   out_sat,
    input  logic                   clr_count,
    output logic [CNT_W-1:0]       sat_count
);

    localparam int AW = 2*cant_bits-1;
    localparam int RW = 2*cant_bits;

    localparam logic signed [RW-1:0] RND  = RW'(1) << (FRAC-1);
    localparam logic signed [RW-1:0] MAXV = (RW'(1) << (cant_bits-1)) - RW'(1);
    localparam logic signed [RW-1:0] MINV = ~MAXV;

    logic                    valid_a;
    logic signed [RW-1:0]    r_a;
    logic signed [RW-1:0]    s_val;
    logic                    sat_hi;
    logic                    sat_lo;
    logic [cant_bits-1:0]    s_clamped;
    logic                    adv_a;
    logic                    adv_b;

    assign adv_b    = !out_valid || out_ready;
    assign adv_a    = adv_b || !valid_a;
    assign in_ready = adv_a;

    always_comb begin
        s_val     = r_a >>> FRAC;
        sat_hi    = s_val > MAXV;
        sat_lo    = s_val < MINV;
        s_clamped = s_val[cant_bits-1:0];
        if (sat_hi) begin
            s_clamped = MAXV[cant_bits-1:0];
        end else if (sat_lo) begin
            s_clamped = MINV[cant_bits-1:0];
        end
    end

    // Stage A: widen by one bit so adding the half-LSB can never overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_a <= 1'b0;
            r_a     <= '0;
        end else if (adv_a) begin
            valid_a <= in_valid;
            if (in_valid) begin
                r_a <= $signed({acc_in[AW-1], acc_in}) + RND;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (adv_b) begin
            out_valid <= valid_a;
            if (valid_a) begin
                out_data <= s_clamped;
                out_sat  <= sat_hi || sat_lo;
            end
        end
    end

    // Clear wins over a coincident increment; the counter sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_count <= '0;
        end else if (clr_count) begin
            sat_count <= '0;
        end else if (adv_b && valid_a && (sat_hi || sat_lo) && !(&sat_count)) begin
            sat_count <= sat_count + CNT_W'(1);
        end
    end

endmodule
